dec_stage_pipe: RTL and testbench
=================================

// Module: dec_stage_pipe
// PURPOSE
// Pipelined syndrome decoder; inverse of the encoder stage. Takes a codeword {zero pad, info, parity}
// (parity in LSBs) for work_mod 0/1/2 = (8,4)/(16,11)/(32,26).
// Corrects any single-bit error, flags uncorrectable patterns, returns right-aligned info bits.
// Sits between the register bank and the output FIFO; valid/ready on both sides.
// PARAMETERS
// AMBA_WORD           32  width of work_mod
// MAX_CODEWORD_WIDTH  32  widest codeword supported (8, 16 or 32 only)
// MAX_INFO_WIDTH      26  widest info field; MAX_PARITY_WIDTH = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH
// PORTS
// clk            in   1                   clock
// rst            in   1                   asynchronous, active-low reset
// in_valid       in   1                   codeword/work_mod valid this cycle
// in_ready       out  1                   stage can accept; transfer when in_valid && in_ready
// data_in        in   MAX_CODEWORD_WIDTH  received codeword, possibly corrupted
// work_mod       in   AMBA_WORD           0:(8,4) 1:(16,11) 2:(32,26); others invalid
// out_valid      out  1                   result valid
// out_ready      in   1                   consumer accepts; transfer when out_valid && out_ready
// data_out       out  MAX_CODEWORD_WIDTH  corrected info, zero-extended
// num_of_errors  out  2                   0 none, 1 corrected, 2 uncorrectable / invalid mode
// BEHAVIOUR
// - Reset: out_valid=0, data_out=0, num_of_errors=0, all pipe valids/regs 0; in_ready=1 after reset.
// - Parity matrices are identical to the encoder's. Row k (parity bit k) = bits [26k+25:26k] of
//   H1=156'hE0_0000_3400_000B, H2=156'h1FC_0000_78E0_0019_B400_055B,
//   H3=156'h3_FFF8_00FF_01FC_3C3C_78EC_CCD9_B6AA_AD5B.
//   Use the low rows/bits for 8/16-bit builds, same as the encoder.
// - S1 (register on accept): latch codeword, mode, valid.
//   Split codeword into info=cw[K+P-1:P] and par=cw[P-1:0], with (K,P)=(4,4)/(11,5)/(26,6).
//   Bits above K+P are ignored.
// - S1->S2 comb: syndrome[k] = ^(info & row_k) ^ par[k], k<P; syndrome bits >=P are 0.
//   Register syndrome, info, par, mode, valid in S2.
// - S2->S3 comb:
//   - syndrome==0 -> err=0.
//   - syndrome == column j of H_info, i.e. {row_P-1[j]..row_0[j]} for j<K -> flip info[j], err=1.
//   - syndrome one-hot at bit k<P -> parity error; info unchanged; err=1.
//   - otherwise err=2; info passed uncorrected.
//   - Column match has priority over one-hot; lowest j wins on ties.
// - S3 output register: data_out={0,info_corrected[K-1:0]}, num_of_errors=err.
// - Invalid work_mod (>2, or mode beyond build width): data_out=0, num_of_errors=2.
// - Latency: 3 cycles from accepted input to out_valid, with no stall. Throughput 1/clk.
// - Backpressure: stall = out_valid && !out_ready. Stall freezes S1..S3 and drives in_ready=0.
//   Bubbles are not collapsed: in_ready = !stall. Outputs hold stable while stalled.
// - Simultaneous accept and output transfer in the same cycle is legal; no loss, no duplication.
// - work_mod travels with its data; changing mode mid-stream affects only later inputs.
// - Async reset mid-operation discards all in-flight words; first valid output only after new inputs.
// TESTING
// 1. mode0, data_in=32'h13 (info 1, parity 0011) -> 3 clk later data_out=32'h1, num_of_errors=0.
// 2. mode0, data_in=32'h03 (info bit0 flipped) -> syndrome 0011 -> data_out=32'h1, num_of_errors=1.
// 3. mode0, data_in=32'h1A (bits 0,3 flipped) -> syndrome 1001 -> data_out=32'h1, num_of_errors=2.
// 4. mode0, data_in=32'h12 (parity bit0 flipped) -> data_out=32'h1, num_of_errors=1;
//    then mode=3, any data -> data_out=0, num_of_errors=2.
// 5. Stream 8 mode2 words, out_ready low for cycles 4-6 -> in_ready=0 during stall;
//    all 8 results arrive in order, none lost or duplicated.
// 6. rst low while 3 words in flight -> out_valid=0 next cycle, outputs 0;
//    after release, new word decodes in 3 clk.
// 7. Random sweep, all modes: encode via encoder model, inject 0/1/2 random bit flips.
//    -> info restored for 0/1 flips, err matches; for 2 flips, err=2 or a miscorrection logged
//    only when the syndrome matches a column.

Source files
------------

// File: rtl/dec_stage_pipe.sv
// dec_stage_pipe: three-stage syndrome decoder for (8,4), (16,11) and (32,26) codewords.
// S1 captures the codeword, S2 holds info and syndrome, S3 holds corrected info and error count.
module dec_stage_pipe #(
   parameter int AMBA_WORD          = 32,
   parameter int MAX_CODEWORD_WIDTH = 32,
   parameter int MAX_INFO_WIDTH     = 26
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
   input  logic [AMBA_WORD-1:0]          work_mod,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
   output logic [1:0]                    num_of_errors
);

   // A word moves on in_valid && in_ready and on out_valid && out_ready; a held output
   // (out_valid && !out_ready) freezes every stage, bubbles included, so in_ready = !stall.

   // Row k of each matrix is entry [k]; the info column j of row k is bit j.
   localparam logic [5:0][25:0] H1 = 156'hE0_0000_3400_000B;
   localparam logic [5:0][25:0] H2 = 156'h1FC_0000_78E0_0019_B400_055B;
   localparam logic [5:0][25:0] H3 = 156'h3_FFF8_00FF_01FC_3C3C_78EC_CCD9_B6AA_AD5B;
   localparam logic [1:0]       MODE_BAD = 2'd3;

   function automatic int k_of(input logic [1:0] m);
      case (m)
         2'd0:    return 4;
         2'd1:    return 11;
         2'd2:    return 26;
         default: return 0;
      endcase
   endfunction

   function automatic int p_of(input logic [1:0] m);
      case (m)
         2'd0:    return 4;
         2'd1:    return 5;
         2'd2:    return 6;
         default: return 0;
      endcase
   endfunction

   function automatic logic [25:0] row_of(input logic [1:0] m, input logic [2:0] k);
      case (m)
         2'd0:    return H1[k];
         2'd1:    return H2[k];
         2'd2:    return H3[k];
         default: return '0;
      endcase
   endfunction

   logic                          stall;
   logic [1:0]                    in_mode;
   logic [31:0]                   cw_in;

   logic                          s1_valid_q;
   logic [1:0]                    s1_mode_q;
   logic [31:0]                   s1_cw_q;

   logic [25:0]                   s2_info_d, s2_info_q;
   logic [5:0]                    s2_syn_d, s2_syn_q;
   logic                          s2_valid_q;
   logic [1:0]                    s2_mode_q;

   logic [5:0][25:0]              s3_rows;
   logic [5:0]                    s3_col;
   logic                          s3_hit;
   logic [25:0]                   s3_info_d;
   logic [1:0]                    s3_err_d;
   logic [MAX_CODEWORD_WIDTH-1:0] data_out_d;

   logic                          out_valid_q;
   logic [MAX_CODEWORD_WIDTH-1:0] data_out_q;
   logic [1:0]                    err_q;

   assign stall         = out_valid_q && !out_ready;
   assign in_ready      = !stall;
   assign out_valid     = out_valid_q;
   assign data_out      = data_out_q;
   assign num_of_errors = err_q;
   assign cw_in         = 32'(data_in);

   // Modes wider than this build are folded into the invalid code at the input.
   always_comb begin
      in_mode = MODE_BAD;
      if (work_mod == AMBA_WORD'(0))      in_mode = 2'd0;
      else if (work_mod == AMBA_WORD'(1)) in_mode = 2'd1;
      else if (work_mod == AMBA_WORD'(2)) in_mode = 2'd2;
      if (in_mode != MODE_BAD &&
          (k_of(in_mode) > MAX_INFO_WIDTH ||
           k_of(in_mode) + p_of(in_mode) > MAX_CODEWORD_WIDTH))
         in_mode = MODE_BAD;
   end

   always_comb begin
      s2_info_d = '0;
      s2_syn_d  = '0;
      case (s1_mode_q)
         2'd0:    s2_info_d[3:0]  = s1_cw_q[7:4];
         2'd1:    s2_info_d[10:0] = s1_cw_q[15:5];
         2'd2:    s2_info_d       = s1_cw_q[31:6];
         default: s2_info_d       = '0;
      endcase
      for (int k = 0; k < 6; k++)
         if (k < p_of(s1_mode_q))
            s2_syn_d[k] = (^(s2_info_d & row_of(s1_mode_q, 3'(k)))) ^ s1_cw_q[k];
   end

   // Info-column matches win over parity one-hots; the lowest matching column is taken.
   always_comb begin
      s3_hit    = 1'b0;
      s3_col    = '0;
      s3_info_d = s2_info_q;
      s3_err_d  = 2'd2;
      for (int k = 0; k < 6; k++)
         s3_rows[k] = row_of(s2_mode_q, 3'(k));
      if (s2_mode_q == MODE_BAD) begin
         s3_info_d = '0;
         s3_err_d  = 2'd2;
      end else if (s2_syn_q == '0) begin
         s3_err_d = 2'd0;
      end else begin
         for (int j = 0; j < 26; j++) begin
            s3_col = '0;
            for (int k = 0; k < 6; k++)
               if (k < p_of(s2_mode_q))
                  s3_col[k] = s3_rows[k][j];
            if (!s3_hit && j < k_of(s2_mode_q) && s3_col == s2_syn_q) begin
               s3_hit       = 1'b1;
               s3_info_d[j] = ~s2_info_q[j];
               s3_err_d     = 2'd1;
            end
         end
         if (!s3_hit && ((s2_syn_q & (s2_syn_q - 6'd1)) == 6'd0))
            s3_err_d = 2'd1;
      end
      data_out_d = MAX_CODEWORD_WIDTH'({6'd0, s3_info_d});
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q  <= 1'b0;
         s1_mode_q   <= 2'd0;
         s1_cw_q     <= '0;
         s2_valid_q  <= 1'b0;
         s2_mode_q   <= 2'd0;
         s2_info_q   <= '0;
         s2_syn_q    <= '0;
         out_valid_q <= 1'b0;
         data_out_q  <= '0;
         err_q       <= 2'd0;
      end else if (!stall) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_mode_q <= in_mode;
            s1_cw_q   <= cw_in;
         end
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_mode_q <= s1_mode_q;
            s2_info_q <= s2_info_d;
            s2_syn_q  <= s2_syn_d;
         end
         out_valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            data_out_q <= data_out_d;
            err_q      <= s3_err_d;
         end
      end
   end

endmodule

// File: tb/tb_dec_stage_pipe.sv
// tb_dec_stage_pipe: scoreboard bench for dec_stage_pipe; expectations come from the code tables
// (encoder and brute-force nearest-codeword search), results are popped as the DUT emits them.
module tb_dec_stage_pipe;

   localparam int W = 34;   // {num_of_errors, data_out}
   localparam logic [155:0] H1 = 156'hE0_0000_3400_000B;
   localparam logic [155:0] H2 = 156'h1FC_0000_78E0_0019_B400_055B;
   localparam logic [155:0] H3 = 156'h3_FFF8_00FF_01FC_3C3C_78EC_CCD9_B6AA_AD5B;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] data_in = '0;
   logic [31:0] work_mod = '0;
   logic        in_ready, out_valid;
   logic [31:0] data_out;
   logic [1:0]  num_of_errors;

   logic [W-1:0] exp_q[$];
   int           n_cmp = 0;
   int           n_fail = 0;
   int           n_stall = 0;
   int           n_miscorr = 0;
   int           n_two = 0;
   logic         held_v = 1'b0;
   logic [W-1:0] held;
   logic         rand_done;

   always #5 clk = ~clk;

   dec_stage_pipe #(.AMBA_WORD(32), .MAX_CODEWORD_WIDTH(32), .MAX_INFO_WIDTH(26)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
      .work_mod(work_mod), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
      .num_of_errors(num_of_errors)
   );

   function automatic int klen(input int m);
      return (m == 0) ? 4 : (m == 1) ? 11 : 26;
   endfunction

   function automatic int plen(input int m);
      return (m == 0) ? 4 : (m == 1) ? 5 : 6;
   endfunction

   function automatic logic [5:0] enc_par(input int m, input logic [25:0] info);
      logic [155:0] h;
      logic [5:0]   p;
      h = (m == 0) ? H1 : (m == 1) ? H2 : H3;
      p = '0;
      for (int k = 0; k < plen(m); k++) p[k] = ^(info & h[26*k +: 26]);
      return p;
   endfunction

   function automatic logic [31:0] encode(input int m, input logic [25:0] info);
      return (32'(info) << plen(m)) | 32'(enc_par(m, info));
   endfunction

   // Nearest codeword search: no error, then single info flips (lowest first), then parity flips.
   function automatic logic [W-1:0] model_decode(input int m, input logic [31:0] cw);
      logic [25:0] info;
      logic [5:0]  par;
      info = 26'((cw >> plen(m)) & ((32'd1 << klen(m)) - 32'd1));
      par  = 6'(cw & ((32'd1 << plen(m)) - 32'd1));
      if (enc_par(m, info) == par) return {2'd0, 32'(info)};
      for (int j = 0; j < klen(m); j++)
         if (enc_par(m, info ^ (26'd1 << j)) == par) return {2'd1, 32'(info ^ (26'd1 << j))};
      for (int k = 0; k < plen(m); k++)
         if ((enc_par(m, info) ^ par) == (6'd1 << k)) return {2'd1, 32'(info)};
      return {2'd2, 32'(info)};
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [31:0] cw, input logic [31:0] mode, input logic [W-1:0] exp);
      int waits = 0;
      in_valid = 1'b1;
      data_in  = cw;
      work_mod = mode;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waits++;
         if (waits > 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0 for 200 cycles, required 1");
            break;
         end
      end
      if (in_ready) exp_q.push_back(exp);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic lat_check(input string name);
      int lat = 1;
      while (lat < 20) begin
         @(negedge clk);
         if (out_valid) break;
         lat++;
      end
      check(name, W'(lat), W'(3));
   endtask

   task automatic wait_drain(input string name);
      int c = 0;
      while (exp_q.size() != 0 && c < 300) begin
         @(negedge clk);
         c++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d results outstanding, required 0", name, exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         held_v = 1'b0;
      end else begin
         if (out_valid && !out_ready) begin
            n_stall++;
            check("in_ready_stall", W'(in_ready), W'(0));
            if (held_v) check("hold_stable", {num_of_errors, data_out}, held);
            held   = {num_of_errors, data_out};
            held_v = 1'b1;
         end else begin
            held_v = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_output: got %h, required no output", {num_of_errors, data_out});
            end else begin
               check("result", {num_of_errors, data_out}, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_outputs", {num_of_errors, data_out}, W'(0));
      check("rst_in_ready", W'(in_ready), W'(1));
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("in_ready_after_rst", W'(in_ready), W'(1));

      // Directed (8,4) cases and invalid modes
      send(32'h13, 32'd0, {2'd0, 32'h1});
      lat_check("latency_first");
      wait_drain("drain_t1");
      send(32'h03, 32'd0, {2'd1, 32'h1});
      send(32'h1A, 32'd0, {2'd2, 32'h1});
      send(32'h12, 32'd0, {2'd1, 32'h1});
      send(32'hAB, 32'd3, {2'd2, 32'h0});
      send(32'h5, 32'hFFFF_FFFF, {2'd2, 32'h0});
      send(32'hFFFF_FF13, 32'd0, {2'd0, 32'h1});
      send(encode(1, 26'h7FF) ^ 32'h8000, 32'd1, {2'd1, 32'h7FF});
      send(encode(2, 26'h3FF_FFFF) ^ 32'h8000_0000, 32'd2, {2'd1, 32'h3FF_FFFF});
      send(encode(2, 26'h155_5555) ^ 32'h20, 32'd2, {2'd1, 32'h155_5555});
      wait_drain("drain_directed");

      // Eight (32,26) words with out_ready low for cycles 4-6
      s0 = n_stall;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               logic [25:0] v;
               v = 26'($urandom());
               send(encode(2, v), 32'd2, {2'd0, 32'(v)});
            end
         end
         begin
            for (int c = 1; c <= 8; c++) begin
               @(posedge clk);
               #1;
               out_ready = !(c >= 4 && c <= 6);
            end
            out_ready = 1'b1;
         end
      join
      wait_drain("drain_stall");
      check("stall_cycles", W'(n_stall - s0), W'(3));

      // Reset with three words in flight
      send(encode(0, 26'h5), 32'd0, {2'd0, 32'h5});
      send(encode(1, 26'h123), 32'd1, {2'd0, 32'h123});
      send(encode(2, 26'h3AB_CDEF), 32'd2, {2'd0, 32'h3AB_CDEF});
      #1 rst = 1'b0;
      #1;
      check("midrst_out_valid", W'(out_valid), W'(0));
      check("midrst_outputs", {num_of_errors, data_out}, W'(0));
      exp_q.delete();
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_ghost_output", W'(out_valid), W'(0));
      end
      @(posedge clk);
      #1;
      send(encode(1, 26'h6B1), 32'd1, {2'd0, 32'h6B1});
      lat_check("latency_after_rst");
      wait_drain("drain_rst");

      // Random sweep with random backpressure
      rand_done = 1'b0;
      fork
         begin
            for (int n = 0; n < 300; n++) begin
               int          m, nf, width, b0, b1;
               logic [25:0] info;
               logic [31:0] cw, wm;
               logic [W-1:0] e;
               if ($urandom_range(0, 9) == 0) begin
                  wm = ($urandom_range(0, 1) != 0) ? 32'd3 : $urandom();
                  if (wm < 32'd3) wm = 32'd3;
                  send($urandom(), wm, {2'd2, 32'd0});
               end else begin
                  m     = int'($urandom_range(0, 2));
                  info  = 26'($urandom()) & 26'((32'd1 << klen(m)) - 32'd1);
                  cw    = encode(m, info);
                  width = klen(m) + plen(m);
                  if (width < 32) cw = cw | ($urandom() << width);
                  nf = int'($urandom_range(0, 2));
                  b0 = int'($urandom_range(0, width - 1));
                  b1 = (b0 + int'($urandom_range(1, width - 1))) % width;
                  if (nf >= 1) cw = cw ^ (32'd1 << b0);
                  if (nf == 2) cw = cw ^ (32'd1 << b1);
                  if (nf < 2) begin
                     e = {2'(nf), 32'(info)};
                  end else begin
                     e = model_decode(m, cw);
                     n_two++;
                     if (e[33:32] == 2'd1) n_miscorr++;
                  end
                  send(cw, 32'(m), e);
               end
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      wait_drain("drain_random");
      $display("random sweep: %0d two-flip words, %0d decoded as a single-column correction",
               n_two, n_miscorr);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
